param_router: RTL and testbench

- Parametrised successor of the two-way class router, scaled to NUM_IN upstream sources and NUM_OUT class-indexed output FIFOs.
- Each cycle a round-robin arbiter selects one non-empty upstream FIFO whose head word can be accepted, pops it, decodes its class field and writes its payload into the matching output FIFO.
- Each output FIFO reports full, empty, almost-full, almost-empty, pause and sticky error flags; a global Error ORs all error sources.
- Sits between the ingress FIFOs and the per-class egress logic of the PCIe switch datapath.

---
 rtl/param_router_pkg.sv | 26 ++
 rtl/param_router_if.sv | 54 +++++
 rtl/param_router_fifo.sv | 79 +++++++
 rtl/param_router.sv | 140 ++++++++++++++
 tb/tb_param_router.sv | 225 ++++++++++++++++++++++
 5 files changed

// File: rtl/param_router_pkg.sv
// Shared definitions for param_router: default widths and thresholds, the
// per-FIFO flag bundle, and a width helper. Optional export: PARAM_ROUTER_OCCUPANCY_EN.
package param_router_pkg;

  localparam int DEF_NUM_IN  = 2;
  localparam int DEF_NUM_OUT = 4;
  localparam int DEF_DATA_W  = 8;
  localparam int DEF_CLASS_W = 2;
  localparam int DEF_DEPTH   = 8;
  localparam int DEF_AF_THR  = 6;
  localparam int DEF_AE_THR  = 2;

  // Registered status of one output FIFO; error is the sticky underflow bit.
  typedef struct packed {
    logic error;
    logic aempty;
    logic afull;
    logic full;
    logic empty;
  } fifo_flags_t;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/param_router_if.sv
// Upstream/downstream bus of param_router. The fifo_count signal exists only
// when PARAM_ROUTER_OCCUPANCY_EN is defined.
// Handshake: a source word transfers on a rising edge where in_empty=0 and
// in_pop=1 in the same cycle; a FIFO read transfers where out_pop=1 and fifo_empty=0.
interface param_router_if
  import param_router_pkg::*;
#(
  parameter int NUM_IN  = DEF_NUM_IN,
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLASS_W = DEF_CLASS_W
`ifdef PARAM_ROUTER_OCCUPANCY_EN
  , parameter int DEPTH = DEF_DEPTH
`endif
);

  localparam int IN_W = DATA_W + CLASS_W;

  logic [NUM_IN*IN_W-1:0]    in_data;
  logic [NUM_IN-1:0]         in_empty;
  logic [NUM_IN-1:0]         in_pop;
  logic [NUM_OUT-1:0]        out_pop;
  logic [NUM_OUT*DATA_W-1:0] out_data;
  logic [NUM_OUT-1:0]        fifo_empty;
  logic [NUM_OUT-1:0]        fifo_full;
  logic [NUM_OUT-1:0]        almost_full;
  logic [NUM_OUT-1:0]        almost_empty;
  logic [NUM_OUT-1:0]        fifo_pause;
  logic [NUM_OUT-1:0]        fifo_error;
  logic                      class_error;
  logic                      Error;
`ifdef PARAM_ROUTER_OCCUPANCY_EN
  logic [NUM_OUT*cnt_width(DEPTH)-1:0] fifo_count;
`endif

  modport master (
    output in_data, in_empty, out_pop,
    input  in_pop, out_data, fifo_empty, fifo_full, almost_full, almost_empty,
    input  fifo_pause, fifo_error, class_error, Error
`ifdef PARAM_ROUTER_OCCUPANCY_EN
    , input fifo_count
`endif
  );

  modport slave (
    input  in_data, in_empty, out_pop,
    output in_pop, out_data, fifo_empty, fifo_full, almost_full, almost_empty,
    output fifo_pause, fifo_error, class_error, Error
`ifdef PARAM_ROUTER_OCCUPANCY_EN
    , output fifo_count
`endif
  );

endinterface

// File: rtl/param_router_fifo.sv
// router_fifo: one synchronous show-ahead FIFO with occupancy count,
// registered threshold flags and a sticky underflow error.
module router_fifo
  import param_router_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH,
  parameter int AF_THR = DEF_AF_THR,
  parameter int AE_THR = DEF_AE_THR,
  localparam int CNT_W = cnt_width(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              rd_en_i,
  output logic [DATA_W-1:0] rd_data_o,
  output fifo_flags_t       flags_o,
  output logic [CNT_W-1:0]  count_o
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  fifo_flags_t       flags_q, flags_d;
  logic              do_wr, do_rd;

  // A full FIFO refuses writes even when a read frees a slot this cycle.
  assign do_wr = wr_en_i && !flags_q.full;
  assign do_rd = rd_en_i && !flags_q.empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    flags_d.empty  = (count_d == '0);
    flags_d.full   = (count_d == CNT_W'(DEPTH));
    flags_d.afull  = (count_d >= CNT_W'(AF_THR));
    flags_d.aempty = (count_d <= CNT_W'(AE_THR));
    flags_d.error  = flags_q.error || (rd_en_i && flags_q.empty);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
      flags_q.empty  <= 1'b1;
      flags_q.aempty <= 1'b1;
      flags_q.full   <= 1'b0;
      flags_q.afull  <= 1'b0;
      flags_q.error  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      flags_q  <= flags_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign rd_data_o = flags_q.empty ? '0 : mem_q[rd_ptr_q];
  assign flags_o   = flags_q;
  assign count_o   = count_q;

endmodule

// File: rtl/param_router.sv
// param_router: round-robin router from NUM_IN upstream FIFOs into NUM_OUT
// class-indexed output FIFOs. Define PARAM_ROUTER_OCCUPANCY_EN to export fifo_count.
module param_router
  import param_router_pkg::*;
#(
  parameter int NUM_IN  = DEF_NUM_IN,
  parameter int NUM_OUT = DEF_NUM_OUT,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int CLASS_W = DEF_CLASS_W,
  parameter int DEPTH   = DEF_DEPTH,
  parameter int AF_THR  = DEF_AF_THR,
  parameter int AE_THR  = DEF_AE_THR
) (
  input logic           clk,
  input logic           reset,
  param_router_if.slave bus
);

  localparam int IN_W  = DATA_W + CLASS_W;
  localparam int CNT_W = cnt_width(DEPTH);
  localparam int RR_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  logic [CLASS_W-1:0]        src_class [NUM_IN];
  logic [NUM_IN-1:0]         src_bad, src_blocked, src_eligible;
  logic [NUM_IN-1:0]         in_pop;
  logic [NUM_OUT-1:0]        full_vec, wr_en;
  logic [NUM_OUT-1:0]        empty_vec, afull_vec, aempty_vec, error_vec;
  logic [NUM_OUT*DATA_W-1:0] out_data_w;
  logic                      grant_valid, grant_bad;
  logic [RR_W-1:0]           grant_idx;
  logic [CLASS_W-1:0]        grant_class;
  logic [DATA_W-1:0]         grant_data;
  logic [RR_W-1:0]           rr_ptr_q, rr_ptr_d;
  logic                      class_error_q, class_error_d;

  // A source whose class targets a full FIFO is skipped; invalid classes
  // are always eligible so the word can be discarded.
  always_comb begin
    for (int i = 0; i < NUM_IN; i++) begin
      src_class[i]   = bus.in_data[i*IN_W+DATA_W +: CLASS_W];
      src_bad[i]     = (int'(src_class[i]) >= NUM_OUT);
      src_blocked[i] = 1'b0;
      for (int k = 0; k < NUM_OUT; k++) begin
        if (int'(src_class[i]) == k) src_blocked[i] = full_vec[k];
      end
      src_eligible[i] = !bus.in_empty[i] && (src_bad[i] || !src_blocked[i]);
    end
  end

  // rr_ptr_q holds the first source to examine, i.e. last grant + 1.
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = rr_ptr_q;
    if (!reset) begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (!grant_valid && src_eligible[(int'(rr_ptr_q) + k) % NUM_IN]) begin
          grant_valid = 1'b1;
          grant_idx   = RR_W'((int'(rr_ptr_q) + k) % NUM_IN);
        end
      end
    end
    grant_class = src_class[grant_idx];
    grant_bad   = src_bad[grant_idx];
    grant_data  = bus.in_data[int'(grant_idx)*IN_W +: DATA_W];

    in_pop = '0;
    if (grant_valid) in_pop[grant_idx] = 1'b1;

    wr_en = '0;
    for (int k = 0; k < NUM_OUT; k++) begin
      wr_en[k] = grant_valid && !grant_bad && (int'(grant_class) == k);
    end

    rr_ptr_d = rr_ptr_q;
    if (grant_valid) begin
      rr_ptr_d = (int'(grant_idx) == NUM_IN - 1) ? '0 : grant_idx + RR_W'(1);
    end
    class_error_d = class_error_q || (grant_valid && grant_bad);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rr_ptr_q      <= '0;
      class_error_q <= 1'b0;
    end else begin
      rr_ptr_q      <= rr_ptr_d;
      class_error_q <= class_error_d;
    end
  end

  for (genvar k = 0; k < NUM_OUT; k++) begin : g_fifo
    fifo_flags_t flags;
`ifdef PARAM_ROUTER_OCCUPANCY_EN
    logic [CNT_W-1:0] cnt;
`else
    logic [CNT_W-1:0] cnt_unused;
`endif

    router_fifo #(
      .DATA_W (DATA_W),
      .DEPTH  (DEPTH),
      .AF_THR (AF_THR),
      .AE_THR (AE_THR)
    ) u_fifo (
      .clk_i     (clk),
      .rst_i     (reset),
      .wr_en_i   (wr_en[k]),
      .wr_data_i (grant_data),
      .rd_en_i   (bus.out_pop[k]),
      .rd_data_o (out_data_w[k*DATA_W +: DATA_W]),
      .flags_o   (flags),
`ifdef PARAM_ROUTER_OCCUPANCY_EN
      .count_o   (cnt)
`else
      .count_o   (cnt_unused)
`endif
    );

    assign empty_vec[k]  = flags.empty;
    assign full_vec[k]   = flags.full;
    assign afull_vec[k]  = flags.afull;
    assign aempty_vec[k] = flags.aempty;
    assign error_vec[k]  = flags.error;
`ifdef PARAM_ROUTER_OCCUPANCY_EN
    assign bus.fifo_count[k*CNT_W +: CNT_W] = cnt;
`endif
  end

  assign bus.in_pop       = in_pop;
  assign bus.out_data     = out_data_w;
  assign bus.fifo_empty   = empty_vec;
  assign bus.fifo_full    = full_vec;
  assign bus.almost_full  = afull_vec;
  assign bus.almost_empty = aempty_vec;
  assign bus.fifo_pause   = afull_vec;
  assign bus.fifo_error   = error_vec;
  assign bus.class_error  = class_error_q;
  assign bus.Error        = (|error_vec) || class_error_q;

endmodule

// File: tb/tb_param_router.sv
// Directed bench for param_router (default build and PARAM_ROUTER_OCCUPANCY_EN).
// A second instance with NUM_OUT=3 exercises the invalid-class path.
module tb_param_router;
  import param_router_pkg::*;

  localparam int IN_W = DEF_DATA_W + DEF_CLASS_W;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  param_router_if bus ();
  param_router_if #(.NUM_OUT(3)) bus3 ();

  param_router u_dut (.clk(clk), .reset(reset), .bus(bus));
  param_router #(.NUM_OUT(3)) u_dut3 (.clk(clk), .reset(reset), .bus(bus3));

  int n_checks = 0;
  int n_err    = 0;
  logic [IN_W-1:0] src0_q[$];
  logic [IN_W-1:0] src1_q[$];
  int              pop_log[$];
  logic [7:0]      exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic drive_src();
    bus.in_empty[0] = (src0_q.size() == 0);
    bus.in_empty[1] = (src1_q.size() == 0);
    bus.in_data[IN_W-1:0]      = (src0_q.size() != 0) ? src0_q[0] : '0;
    bus.in_data[2*IN_W-1:IN_W] = (src1_q.size() != 0) ? src1_q[0] : '0;
    #1;
  endtask

  // One clock: upstream FIFOs pop whatever the DUT granted before the edge.
  task automatic cycle();
    logic [1:0] pops;
    #1;
    pops = bus.in_pop;
    @(posedge clk);
    if (pops[0]) begin void'(src0_q.pop_front()); pop_log.push_back(0); end
    if (pops[1]) begin void'(src1_q.pop_front()); pop_log.push_back(1); end
    #1;
    drive_src();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    src0_q.delete();
    src1_q.delete();
    pop_log.delete();
    bus.out_pop   = '0;
    bus3.in_data  = '0;
    bus3.in_empty = '1;
    bus3.out_pop  = '0;
    drive_src();
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #2;
  endtask

  initial begin
    reset         = 1'b0;
    bus.in_data   = '0;
    bus.in_empty  = '1;
    bus.out_pop   = '0;
    bus3.in_data  = '0;
    bus3.in_empty = '1;
    bus3.out_pop  = '0;
    #2 reset = 1'b1;
    #2;
    check("rst_empty", 32'(bus.fifo_empty), 32'hF);
    check("rst_aempty", 32'(bus.almost_empty), 32'hF);
    check("rst_full", 32'(bus.fifo_full), 32'h0);
    check("rst_afull", 32'(bus.almost_full), 32'h0);
    check("rst_pause", 32'(bus.fifo_pause), 32'h0);
    check("rst_err", {bus.fifo_error, bus.class_error, bus.Error}, 32'h0);
    check("rst_data", bus.out_data, 32'h0);
    check("rst_pop", 32'(bus.in_pop), 32'h0);
    do_reset();

    // Reset asserted while words are in flight.
    src0_q = '{10'h105, 10'h106, 10'h107};
    drive_src();
    cycle();
    cycle();
    check("mid_fill", 32'(bus.fifo_empty), 32'b1101);
    check("mid_pop_pre", 32'(bus.in_pop), 32'b01);
    reset = 1'b1;
    #1;
    check("mid_empty", 32'(bus.fifo_empty), 32'hF);
    check("mid_pop", 32'(bus.in_pop), 32'h0);
    check("mid_data", bus.out_data, 32'h0);
    do_reset();
    src0_q.push_back(10'h2A5);
    drive_src();
    check("post_pop", 32'(bus.in_pop), 32'b01);
    cycle();
    check("post_data", 32'(bus.out_data[23:16]), 32'hA5);
    check("post_empty", 32'(bus.fifo_empty), 32'b1011);

    // Round-robin alternation into class 1.
    do_reset();
    src0_q = '{10'h111, 10'h122};
    src1_q = '{10'h133, 10'h144};
    drive_src();
    repeat (4) cycle();
    check("rr_npops", pop_log.size(), 32'd4);
    for (int i = 0; i < 4 && i < pop_log.size(); i++) check("rr_order", pop_log[i], i % 2);
    exp_q = '{8'h11, 8'h33, 8'h22, 8'h44};
    while (exp_q.size() != 0) begin
      check("rr_data", 32'(bus.out_data[15:8]), 32'(exp_q.pop_front()));
      bus.out_pop = 4'b0010;
      cycle();
      bus.out_pop = '0;
    end
    check("rr_drained", 32'(bus.fifo_empty), 32'hF);

    // Fill class 3 and watch the thresholds.
    do_reset();
    for (int i = 0; i < 8; i++) src0_q.push_back(10'h300 + 10'(i));
    drive_src();
    for (int n = 1; n <= 8; n++) begin
      cycle();
      check("fill_aempty", 32'(bus.almost_empty[3]), 32'(n <= 2));
      check("fill_afull", 32'(bus.almost_full[3]), 32'(n >= 6));
      check("fill_pause", 32'(bus.fifo_pause[3]), 32'(n >= 6));
      check("fill_full", 32'(bus.fifo_full[3]), 32'(n == 8));
    end
    src0_q.push_back(10'h3AA);
    src1_q = '{10'h0C1, 10'h0C2};
    drive_src();
    check("hol_pop1", 32'(bus.in_pop), 32'b10);
    cycle();
    check("hol_c0_data", 32'(bus.out_data[7:0]), 32'hC1);
    check("hol_pop2", 32'(bus.in_pop), 32'b10);
    cycle();
    check("hol_src0_left", src0_q.size(), 32'd1);
    check("hol_full", 32'(bus.fifo_full[3]), 32'h1);
`ifdef PARAM_ROUTER_OCCUPANCY_EN
    check("occ_full", 32'(bus.fifo_count[15:12]), 32'd8);
`endif

    // Read on a full FIFO with a pending write: read only, then the write.
    bus.out_pop = 4'b1000;
    #1;
    check("rw_pop_blocked", 32'(bus.in_pop), 32'h0);
    cycle();
    bus.out_pop = '0;
    #1;
    check("rw_full_clr", 32'(bus.fifo_full[3]), 32'h0);
    check("rw_afull", 32'(bus.almost_full[3]), 32'h1);
    check("rw_head", 32'(bus.out_data[31:24]), 32'h01);
    check("rw_pop_ok", 32'(bus.in_pop), 32'b01);
`ifdef PARAM_ROUTER_OCCUPANCY_EN
    check("occ_seven", 32'(bus.fifo_count[15:12]), 32'd7);
`endif
    cycle();
    check("rw_full_set", 32'(bus.fifo_full[3]), 32'h1);
    exp_q = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'hAA};
    while (exp_q.size() != 0) begin
      check("rw_drain", 32'(bus.out_data[31:24]), 32'(exp_q.pop_front()));
      bus.out_pop = 4'b1000;
      cycle();
      bus.out_pop = '0;
    end
    check("rw_empty", 32'(bus.fifo_empty[3]), 32'h1);

    // Underflow is sticky and leaves the FIFO untouched.
    do_reset();
    check("uf_pre", 32'(bus.Error), 32'h0);
    bus.out_pop = 4'b0001;
    cycle();
    bus.out_pop = '0;
    check("uf_err", 32'(bus.fifo_error), 32'b0001);
    check("uf_global", 32'(bus.Error), 32'h1);
    repeat (3) cycle();
    check("uf_sticky", 32'(bus.fifo_error), 32'b0001);
    check("uf_empty", 32'(bus.fifo_empty), 32'hF);
    src0_q.push_back(10'h0BB);
    drive_src();
    cycle();
    check("uf_ptr", 32'(bus.out_data[7:0]), 32'hBB);

    // Invalid class on the three-output instance.
    do_reset();
    check("ce_pre", 32'(bus3.class_error), 32'h0);
    bus3.in_data[IN_W-1:0] = 10'h355;
    bus3.in_empty = 2'b10;
    #1;
    check("ce_pop", 32'(bus3.in_pop), 32'b01);
    @(posedge clk);
    #1;
    bus3.in_empty = 2'b11;
    #1;
    check("ce_flag", 32'(bus3.class_error), 32'h1);
    check("ce_global", 32'(bus3.Error), 32'h1);
    check("ce_dropped", 32'(bus3.fifo_empty), 32'b111);

`ifdef PARAM_ROUTER_OCCUPANCY_EN
    do_reset();
    check("occ_rst", 32'(bus.fifo_count), 32'h0);
    for (int i = 1; i <= 5; i++) src0_q.push_back(10'(i));
    drive_src();
    repeat (5) cycle();
    check("occ_five", 32'(bus.fifo_count[3:0]), 32'd5);
    bus.out_pop = 4'b0001;
    repeat (2) cycle();
    bus.out_pop = '0;
    #1;
    check("occ_three", 32'(bus.fifo_count[3:0]), 32'd3);
`endif

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
